// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle for the digit-serial packed-BCD adder.
// The master issues operands and start; the slave returns status and the result.
interface bcd_serial_adder_if #(
  parameter int unsigned DIGITS = 4
) ();
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Packed-BCD adder using one decimal digit-add datapath.
// Operands are processed one digit per clock, least-significant digit first.
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_serial_adder_if.slave bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    work;
  logic [W-1:0]    work_nxt;
  logic            carry;
  logic            carry_nxt;
  logic            err_acc;
  logic            dig_bad;
  logic            last;
  logic [IW-1:0]   idx;
  logic [IW+1:0]   base;
  logic [3:0]      ad;
  logic [3:0]      bd;
  logic [3:0]      digit;
  logic [4:0]      t;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            err_q;

  always_comb begin
    base      = {idx, 2'b00};
    ad        = a_q[base +: 4];
    bd        = b_q[base +: 4];
    t         = {1'b0, ad} + {1'b0, bd} + {4'b0000, carry};
    carry_nxt = (t > 5'd9);
    // (t+6) mod 16 only depends on the low nibble of t
    digit     = carry_nxt ? (t[3:0] + 4'd6) : t[3:0];
    dig_bad   = (ad > 4'd9) || (bd > 4'd9);
    last      = (idx == IW'(DIGITS - 1));
    work_nxt  = work;
    work_nxt[base +: 4] = digit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work    <= '0;
      carry   <= 1'b0;
      err_acc <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry   <= bus.cin;
            idx     <= '0;
            err_acc <= 1'b0;
            work    <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          work    <= work_nxt;
          carry   <= carry_nxt;
          err_acc <= err_acc | dig_bad;
          if (last) begin
            sum_q  <= work_nxt;
            cout_q <= carry_nxt;
            err_q  <= err_acc | dig_bad;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;
endmodule
